// File: rtl/sh_regfile_bank_if.sv
// Register-file access bundle: immediate/deferred write ports, two read ports,
// R0 shadow, status and raw debug read.
interface sh_regfile_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              CE;
    logic              BANK;

    logic [ADDR_W-1:0] WA_ADDR;
    logic [DATA_W-1:0] WA_D;
    logic              WAE;
    logic              WA_ALT;

    logic [ADDR_W-1:0] WB_ADDR;
    logic [DATA_W-1:0] WB_D;
    logic              WBE;
    logic              WB_ALT;

    logic [ADDR_W-1:0] RA_ADDR;
    logic [ADDR_W-1:0] RB_ADDR;
    logic              RA_ALT;
    logic              RB_ALT;
    logic [DATA_W-1:0] RA_Q;
    logic [DATA_W-1:0] RB_Q;
    logic [DATA_W-1:0] R0_Q;

    logic              WB_BUSY;
    logic              ERR;

    logic [ADDR_W:0]   DBG_ADDR;
    logic [DATA_W-1:0] DBG_Q;

    modport master (
        output CE, BANK,
        output WA_ADDR, WA_D, WAE, WA_ALT,
        output WB_ADDR, WB_D, WBE, WB_ALT,
        output RA_ADDR, RB_ADDR, RA_ALT, RB_ALT,
        output DBG_ADDR,
        input  RA_Q, RB_Q, R0_Q, WB_BUSY, ERR, DBG_Q
    );

    modport slave (
        input  CE, BANK,
        input  WA_ADDR, WA_D, WAE, WA_ALT,
        input  WB_ADDR, WB_D, WBE, WB_ALT,
        input  RA_ADDR, RB_ADDR, RA_ALT, RB_ALT,
        input  DBG_ADDR,
        output RA_Q, RB_Q, R0_Q, WB_BUSY, ERR, DBG_Q
    );
endinterface

// File: rtl/sh_regfile_bank.sv
// Banked SH general-register file with one immediate write port, a one-entry
// deferred write port with read forwarding, and per-bank registered R0 shadows.
module sh_regfile_bank #(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 17,
    parameter int BANKED_REGS = 8,
    parameter int NUM_BANKS   = 2,
    parameter int ADDR_W      = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    sh_regfile_bank_if.slave  rf
);
    localparam int PHYS_W = ADDR_W + 1;
    localparam int DEPTH  = NUM_BANKS * BANKED_REGS + NUM_REGS - BANKED_REGS;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Banked registers sit bank-major at the bottom; unbanked ones follow.
    function automatic logic [PHYS_W-1:0] phys(
        input logic [ADDR_W-1:0] addr,
        input logic              alt,
        input logic              bank
    );
        int a;
        int b;
        a = int'(addr);
        b = (NUM_BANKS > 1) ? int'(bank ^ alt) : 0;
        if (a < BANKED_REGS) begin
            return PHYS_W'(b * BANKED_REGS + a);
        end
        return PHYS_W'(NUM_BANKS * BANKED_REGS + a - BANKED_REGS);
    endfunction

    logic [PHYS_W-1:0] wa_p;
    logic [PHYS_W-1:0] wb_p;
    logic [PHYS_W-1:0] ra_p;
    logic [PHYS_W-1:0] rb_p;

    assign wa_p = phys(rf.WA_ADDR, rf.WA_ALT, rf.BANK);
    assign wb_p = phys(rf.WB_ADDR, rf.WB_ALT, rf.BANK);
    assign ra_p = phys(rf.RA_ADDR, rf.RA_ALT, rf.BANK);
    assign rb_p = phys(rf.RB_ADDR, rf.RB_ALT, rf.BANK);

    logic              pend_v_reg;
    logic              pend_v_next;
    logic [PHYS_W-1:0] pend_p_reg;
    logic [DATA_W-1:0] pend_d_reg;
    logic              err_reg;

    logic wa_fire;
    logic wb_cap;
    logic retire;
    logic cancel;
    logic err_set;

    assign wa_fire = rf.CE & rf.WAE;
    assign wb_cap  = rf.CE & rf.WBE;
    // The deferred entry only gets the write port on edges port A leaves idle.
    assign retire  = pend_v_reg & ~wa_fire;
    assign cancel  = pend_v_reg & wa_fire & (wa_p == pend_p_reg);
    assign err_set = wb_cap & pend_v_reg & ~retire;

    logic [DATA_W-1:0] arr_q [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_arr
        localparam logic [PHYS_W-1:0] CELL_P = PHYS_W'(gi);
        logic [DATA_W-1:0] cell_reg;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                cell_reg <= '0;
            end else if (wa_fire && wa_p == CELL_P) begin
                cell_reg <= rf.WA_D;
            end else if (retire && pend_p_reg == CELL_P) begin
                cell_reg <= pend_d_reg;
            end
        end

        assign arr_q[gi] = cell_reg;
    end

    always_comb begin
        pend_v_next = pend_v_reg;
        if (retire || cancel) begin
            pend_v_next = 1'b0;
        end
        if (wb_cap) begin
            pend_v_next = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_v_reg <= 1'b0;
            pend_p_reg <= '0;
            pend_d_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            pend_v_reg <= pend_v_next;
            if (wb_cap) begin
                pend_p_reg <= wb_p;
                pend_d_reg <= rf.WB_D;
            end
            if (err_set) begin
                err_reg <= 1'b1;
            end
        end
    end

    logic [DATA_W-1:0] sh_q [NUM_BANKS];

    // A capture to R0 overrides a same-edge port-A write, matching the final array value.
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_sh
        localparam logic [PHYS_W-1:0] R0_P = PHYS_W'((BANKED_REGS > 0) ? gi * BANKED_REGS : 0);
        logic [DATA_W-1:0] sh_reg;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                sh_reg <= '0;
            end else if (wb_cap && wb_p == R0_P) begin
                sh_reg <= rf.WB_D;
            end else if (wa_fire && wa_p == R0_P) begin
                sh_reg <= rf.WA_D;
            end
        end

        assign sh_q[gi] = sh_reg;
    end

    logic [DATA_W-1:0] ra_raw;
    logic [DATA_W-1:0] rb_raw;
    logic [DATA_W-1:0] dbg_raw;
    logic [DATA_W-1:0] r0_sel;

    always_comb begin
        ra_raw  = '0;
        rb_raw  = '0;
        dbg_raw = '0;
        if (int'(ra_p) < DEPTH) begin
            ra_raw = arr_q[IDX_W'(ra_p)];
        end
        if (int'(rb_p) < DEPTH) begin
            rb_raw = arr_q[IDX_W'(rb_p)];
        end
        if (int'(rf.DBG_ADDR) < DEPTH) begin
            dbg_raw = arr_q[IDX_W'(rf.DBG_ADDR)];
        end
    end

    always_comb begin
        r0_sel = sh_q[0];
        if (NUM_BANKS > 1 && rf.BANK) begin
            r0_sel = sh_q[NUM_BANKS-1];
        end
    end

    assign rf.RA_Q    = (pend_v_reg && pend_p_reg == ra_p) ? pend_d_reg : ra_raw;
    assign rf.RB_Q    = (pend_v_reg && pend_p_reg == rb_p) ? pend_d_reg : rb_raw;
    assign rf.DBG_Q   = dbg_raw;
    assign rf.R0_Q    = r0_sel;
    assign rf.WB_BUSY = pend_v_reg;
    assign rf.ERR     = err_reg;
endmodule
